// File: rtl/txgen.sv
// txgen: bus response frame generator.
// Accepts a sensor read request from the receive parser, fetches 32-bit data
// for that sensor from the data bank, and streams an 11-byte frame
// (DEV_ID, FRM_CNT, SID, DATA little-endian, CRC-16/MODBUS) to the UART.
module txgen #(
   parameter logic [15:0] DEV_ID  = 16'h0001,
   parameter logic [15:0] FRM_CNT = 16'h0007
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [7:0]  ret_cmd,
   input  logic        ret_cmd_flg,
   output logic [7:0]  sen_sel,
   input  logic [31:0] sen_rdata,
   output logic [7:0]  tx_data,
   output logic        tx_en,
   input  logic        tx_busy,
   output logic        busy,
   output logic        frame_done,
   output logic        cmd_drop
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_SEND,
      S_HOLD,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'hA001;
   localparam logic [3:0]  IDX_LAST = 4'd10;
   localparam logic [3:0]  IDX_CRC0 = 4'd8;

   state_t      state_q, state_d;
   logic [7:0]  sid_q, sid_d;
   logic [31:0] data_q, data_d;
   logic [15:0] crc_q, crc_d;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  sen_sel_q, sen_sel_d;
   logic        busy_q, busy_d;
   logic        frame_done_q, frame_done_d;
   logic        cmd_drop_q, cmd_drop_d;

   logic [7:0]  frame_byte;
   logic        send_now;

   // Fold one byte into a reflected CRC-16 (LSB first, 8 shift steps).
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                              input logic [7:0]  byte_in);
      logic [15:0] c;
      c = crc_in ^ {8'h00, byte_in};
      for (int i = 0; i < 8; i++) begin
         if (c[0]) c = (c >> 1) ^ CRC_POLY;
         else      c = c >> 1;
      end
      return c;
   endfunction

   // Select the frame byte for the current index; CRC bytes come straight
   // from the register, which already holds bytes 0..8 by the time idx is 9.
   always_comb begin
      frame_byte = 8'h00;
      case (idx_q)
         4'd0:    frame_byte = DEV_ID[15:8];
         4'd1:    frame_byte = DEV_ID[7:0];
         4'd2:    frame_byte = FRM_CNT[15:8];
         4'd3:    frame_byte = FRM_CNT[7:0];
         4'd4:    frame_byte = sid_q;
         4'd5:    frame_byte = data_q[7:0];
         4'd6:    frame_byte = data_q[15:8];
         4'd7:    frame_byte = data_q[23:16];
         4'd8:    frame_byte = data_q[31:24];
         4'd9:    frame_byte = crc_q[7:0];
         4'd10:   frame_byte = crc_q[15:8];
         default: frame_byte = 8'h00;
      endcase
   end

   // The byte strobe must appear in the SEND cycle itself so that the UART
   // busy rise lands in HOLD; it is therefore decoded from state and tx_busy.
   assign send_now = (state_q == S_SEND) && !tx_busy;
   assign tx_en    = send_now;
   assign tx_data  = send_now ? frame_byte : 8'h00;

   // Next-state and datapath update for the frame sequencer.
   always_comb begin
      state_d      = state_q;
      sid_d        = sid_q;
      data_d       = data_q;
      crc_d        = crc_q;
      idx_d        = idx_q;
      sen_sel_d    = sen_sel_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      cmd_drop_d   = ret_cmd_flg && (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (ret_cmd_flg) begin
               sid_d     = ret_cmd;
               sen_sel_d = ret_cmd;
               busy_d    = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_FETCH: begin
            // Bank read data becomes valid one cycle after sen_sel changes.
            state_d = S_LATCH;
         end
         S_LATCH: begin
            data_d  = sen_rdata;
            crc_d   = CRC_INIT;
            idx_d   = 4'd0;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (!tx_busy) begin
               if (idx_q <= IDX_CRC0) crc_d = crc16_byte(crc_q, frame_byte);
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            // UART busy only rises the cycle after tx_en; ignore it here.
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!tx_busy) begin
               if (idx_q == IDX_LAST) begin
                  frame_done_d = 1'b1;
                  state_d      = S_DONE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = S_SEND;
               end
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any frame in progress.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q      <= S_IDLE;
         sid_q        <= 8'h00;
         data_q       <= 32'h0000_0000;
         crc_q        <= 16'h0000;
         idx_q        <= 4'd0;
         sen_sel_q    <= 8'h00;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         cmd_drop_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sid_q        <= sid_d;
         data_q       <= data_d;
         crc_q        <= crc_d;
         idx_q        <= idx_d;
         sen_sel_q    <= sen_sel_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         cmd_drop_q   <= cmd_drop_d;
      end
   end

   assign sen_sel    = sen_sel_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign cmd_drop   = cmd_drop_q;

endmodule

// File: doc/txgen.md
Name: txgen

Overview:
- Bus response frame generator, directly downstream of the bus receive parser.
- Consumes the parser's read request (`ret_cmd` / `ret_cmd_flg`), fetches 32-bit data for the requested sensor from the sensor data bank, and builds an 11-byte response frame with CRC-16/MODBUS.
- Streams the frame byte-by-byte into the UART transmitter over a `tx_en` / `tx_busy` handshake.

Parameters:
- DEV_ID, 16'h0001, device ID sent as the 2-byte frame head (MSB first).
- FRM_CNT, 16'h0007, count field: number of bytes following the count field (SID + 4 data + 2 CRC).

Ports:
- sys_clk  in  1  system clock, all state on rising edge
- sys_rst  in  1  asynchronous active-low reset
- ret_cmd  in  8  sensor ID to read; valid while ret_cmd_flg is high
- ret_cmd_flg  in  1  one-cycle request pulse from the parser
- sen_sel  out  8  sensor select to the sensor data bank
- sen_rdata  in  32  bank read data; valid 1 cycle after sen_sel changes
- tx_data  out  8  byte to the UART transmitter; valid while tx_en is high
- tx_en  out  1  one-cycle byte-start pulse
- tx_busy  in  1  UART busy; rises the cycle after tx_en and falls when the stop bit ends
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last byte has completed
- cmd_drop  out  1  one-cycle pulse when a request arrives while busy

Behaviour:
- Reset (async, sys_rst=0):
  - state=IDLE; all outputs 0; byte index, CRC and latched SID/data cleared.
  - Reset mid-frame aborts the frame and drops tx_en immediately; no resume.
- Frame byte order (idx 0..10):
  - 0,1: DEV_ID[15:8], DEV_ID[7:0]
  - 2,3: FRM_CNT[15:8], FRM_CNT[7:0]
  - 4: SID
  - 5..8: DATA[7:0], DATA[15:8], DATA[23:16], DATA[31:24]
  - 9,10: CRC[7:0], CRC[15:8]
- CRC-16/MODBUS:
  - Init 16'hFFFF, reflected polynomial 16'hA001, no final XOR.
  - Updated byte-wise (8 combinational shift steps) in the cycle each of bytes 0..8 is issued.
  - Bytes 9/10 come from the CRC register after byte 8 is folded in.
- State machine:
  - IDLE:
    - busy=0.
    - On ret_cmd_flg: latch SID=ret_cmd, drive sen_sel=ret_cmd, go to FETCH.
  - FETCH: 1-cycle wait for bank read latency; go to LATCH.
  - LATCH: DATA<=sen_rdata, CRC<=16'hFFFF, idx<=0; go to SEND.
  - SEND:
    - If tx_busy=0: drive tx_data=byte[idx], pulse tx_en, fold the byte into the CRC if idx<=8, go to HOLD.
    - Otherwise stay in SEND.
  - HOLD: 1-cycle guard in which tx_busy is ignored (UART busy-rise latency); go to WAIT.
  - WAIT:
    - Stay while tx_busy=1.
    - When tx_busy=0: if idx==10 go to DONE; else idx<=idx+1 and go to SEND.
  - DONE: pulse frame_done for 1 cycle; go to IDLE.
- busy:
  - High from the cycle after ret_cmd_flg is accepted through the DONE cycle.
  - Low in IDLE.
- Latency: with tx_busy low, ret_cmd_flg at cycle T gives the first tx_en at T+3.
- Each byte interval is at least 3 cycles (SEND, HOLD, WAIT).
- Boundary conditions:
  - ret_cmd_flg while state != IDLE: ignored; cmd_drop pulses the following cycle; the current frame is unaffected. The DONE cycle counts as busy.
  - ret_cmd_flg in IDLE: accepted even if tx_busy=1; SEND waits for tx_busy low.
  - sen_rdata is sampled only in LATCH; later bank changes do not alter the frame.
  - sen_sel holds SID until the next accepted request.
  - tx_en is never high on two consecutive cycles and never high while in HOLD or WAIT.
  - idx never exceeds 10.

Test Plan:
- Basic read: DEV_ID=16'h0001, ret_cmd=8'h05, sen_rdata=32'h12345678, UART model with 10-cycle busy.
  - Required tx_data sequence: 00 01 00 07 05 78 56 34 12, then CRC low and CRC high.
  - CRC bytes must equal the bench CRC-16/MODBUS of the first 9 bytes; the bench model must self-check ASCII "123456789" -> 16'h4B37.
  - frame_done must pulse once.
- Latency and handshake: tx_busy held low, then 1 cycle after each tx_en.
  - First tx_en at T+3.
  - Exactly 11 tx_en pulses, never on adjacent cycles.
  - busy falls the cycle after frame_done.
- Back-pressure: tx_busy forced high for 50 cycles at request time.
  - No tx_en until tx_busy falls.
  - Frame content is unchanged; sen_rdata changed during the stall must not appear in the frame.
- Overlap: second ret_cmd_flg (8'h09) mid-frame.
  - cmd_drop pulses once.
  - The frame still carries SID 8'h05.
  - A request after frame_done (8'h09) produces a full new frame with SID 09.
- Reset mid-frame: sys_rst low during byte 6.
  - tx_en, busy and sen_sel drop to 0 immediately.
  - After release, a new request sends a complete, correct 11-byte frame starting at 00 01.
